// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus bundle (AW/W/B/AR/R, no IDs or strobes) for the axi4_mem_slave memory endpoint.
interface axi4_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awlen, awsize, awvalid, wdata, wlast, wvalid, bready,
           araddr, arlen, arsize, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awaddr, awlen, awsize, awvalid, wdata, wlast, wvalid, bready,
           araddr, arlen, arsize, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave over a word-addressed RAM with independent write and read FSMs.
// Define AXI4_ASSERT_EN to compile in SVA protocol checks.
module axi4_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input logic             aclk,
  input logic             aresetn,
  axi4_mem_slave_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int SUM_W = ADDR_WIDTH + 11;
  localparam logic [SUM_W-1:0] MEM_BYTES = SUM_W'(4 * MEM_DEPTH);

  // Illegal size, misaligned start, running off the RAM, or crossing a 4 KB page.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size);
    logic [SUM_W-1:0] first;
    logic [SUM_W-1:0] last;
    first = SUM_W'(addr);
    last  = first + (SUM_W'(len) << 2) + SUM_W'(3);
    return (size != 3'b010) || (addr[1:0] != 2'b00) || (last >= MEM_BYTES) ||
           (last[SUM_W-1:12] != first[SUM_W-1:12]);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic [ADDR_WIDTH-1:0] w_addr, r_addr, r_addr_nxt;
  logic [7:0]            w_len, w_cnt, r_len, r_cnt;
  logic                  w_err, r_err, ar_err;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_hs, w_hs, w_final, ar_hs, r_hs, r_final;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign aw_hs      = bus.awvalid && bus.awready;
  assign w_hs       = bus.wvalid && bus.wready;
  assign w_final    = w_hs && (w_cnt == w_len);
  assign ar_hs      = bus.arvalid && bus.arready;
  assign r_hs       = bus.rvalid && bus.rready;
  assign r_final    = r_hs && (r_cnt == r_len);
  assign ar_err     = burst_err(bus.araddr, bus.arlen, bus.arsize);
  assign r_addr_nxt = r_addr + ADDR_WIDTH'(4);

  // ---------------- write channel ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)      w_next = W_DATA;
      W_DATA:  if (w_final)    w_next = W_RESP;
      W_RESP:  if (bus.bready) w_next = W_IDLE;
      default:                 w_next = W_IDLE;
    endcase
  end

  // Readies/valids are gated by reset so every output reads 0 while ARESETn is low.
  always_comb begin
    bus.awready = aresetn && (w_state == W_IDLE);
    bus.wready  = aresetn && (w_state == W_DATA);
    bus.bvalid  = aresetn && (w_state == W_RESP);
    bus.bresp   = (bus.bvalid && w_err) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_addr <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_addr <= bus.awaddr;
      w_len  <= bus.awlen;
      w_cnt  <= '0;
      w_err  <= burst_err(bus.awaddr, bus.awlen, bus.awsize);
    end else if (w_hs) begin
      w_addr <= w_addr + ADDR_WIDTH'(4);
      w_cnt  <= w_cnt + 8'd1;
      if (bus.wlast != (w_cnt == w_len)) w_err <= 1'b1;
    end
  end

  // NOTE: the RAM array has no reset; contents survive ARESETn and only the control path clears.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_err) mem[w_addr[2 +: IDX_W]] <= bus.wdata;
  end

  // ---------------- read channel ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)   r_next = R_DATA;
      R_DATA:  if (r_final) r_next = R_IDLE;
      default:              r_next = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = aresetn && (r_state == R_IDLE);
    bus.rvalid  = aresetn && (r_state == R_DATA);
    bus.rresp   = (bus.rvalid && r_err) ? 2'b10 : 2'b00;
    bus.rlast   = bus.rvalid && (r_cnt == r_len);
    bus.rdata   = rdata_q;
  end

  // RAM is read here, before any same-edge write lands, so a colliding read sees the old word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      rdata_q <= '0;
    end else if (ar_hs) begin
      r_addr  <= bus.araddr;
      r_len   <= bus.arlen;
      r_cnt   <= '0;
      r_err   <= ar_err;
      rdata_q <= ar_err ? '0 : mem[bus.araddr[2 +: IDX_W]];
    end else if (r_hs && !r_final) begin
      r_addr  <= r_addr_nxt;
      r_cnt   <= r_cnt + 8'd1;
      rdata_q <= r_err ? '0 : mem[r_addr_nxt[2 +: IDX_W]];
    end
  end

`ifdef AXI4_ASSERT_EN
  a_aw_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.awvalid && !bus.awready |=> bus.awvalid && $stable({bus.awaddr, bus.awlen, bus.awsize}))
    else $error("awvalid dropped or aw payload changed before awready");
  a_w_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.wvalid && !bus.wready |=> bus.wvalid && $stable({bus.wdata, bus.wlast}))
    else $error("wvalid dropped or w payload changed before wready");
  a_ar_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.arvalid && !bus.arready |=> bus.arvalid && $stable({bus.araddr, bus.arlen, bus.arsize}))
    else $error("arvalid dropped or ar payload changed before arready");
  a_b_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.bvalid && !bus.bready |=> bus.bvalid && $stable(bus.bresp))
    else $error("bvalid dropped or bresp changed before bready");
  a_r_hold: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.rvalid && !bus.rready |=> bus.rvalid && $stable({bus.rdata, bus.rresp, bus.rlast}))
    else $error("rvalid dropped or r payload changed before rready");
  a_rlast: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.rlast |-> bus.rvalid && (r_cnt == r_len))
    else $error("rlast asserted away from final read beat");
  a_b_after_w: assert property (@(posedge aclk) disable iff (!aresetn)
    $rose(bus.bvalid) |-> $past(w_final))
    else $error("bvalid rose without a completed write burst");
  a_no_x: assert property (@(posedge aclk) disable iff (!aresetn)
    (!bus.awvalid || !$isunknown({bus.awaddr, bus.awlen, bus.awsize})) &&
    (!bus.wvalid  || !$isunknown({bus.wdata, bus.wlast})) &&
    (!bus.arvalid || !$isunknown({bus.araddr, bus.arlen, bus.arsize})) &&
    (!bus.bvalid  || !$isunknown(bus.bresp)) &&
    (!bus.rvalid  || !$isunknown({bus.rdata, bus.rresp, bus.rlast})))
    else $error("X on a valid payload");
`endif

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: single/burst transfers, error responses, backpressure, reset abort.
module tb_axi4_mem_slave;

  localparam int TIMEOUT = 50;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi4_mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] wbuf    [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [1:0]  resp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [15:0] addr, input int len, input logic [2:0] size,
                           input int bdelay, input bit good_last, output logic [1:0] bresp_o);
    int  t;
    bit  hs;
    bit  all_ok;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awsize  = size;
    bus.awvalid = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < TIMEOUT) begin hs = bus.awready; tick(); t++; end
    bus.awvalid = 1'b0;
    check("aw_handshake", 32'(hs), 1);
    all_ok = 1'b1;
    for (int i = 0; i <= len; i++) begin
      bus.wdata  = wbuf[i];
      bus.wlast  = good_last && (i == len);
      bus.wvalid = 1'b1;
      t = 0; hs = 1'b0;
      while (!hs && t < TIMEOUT) begin hs = bus.wready; tick(); t++; end
      all_ok = all_ok && hs;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("w_handshakes", 32'(all_ok), 1);
    check("bvalid_after_last_w", 32'(bus.bvalid), 1);
    repeat (bdelay) begin
      tick();
      check("bvalid_held", 32'(bus.bvalid), 1);
    end
    bus.bready = 1'b1;
    bresp_o    = bus.bresp;
    hs         = bus.bvalid;
    tick();
    bus.bready = 1'b0;
    check("b_handshake", 32'(hs), 1);
    check("bvalid_cleared", 32'(bus.bvalid), 0);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int len, input logic [2:0] size,
                          input int stall_beat, input logic [31:0] stall_exp);
    int t;
    bit hs;
    bit all_ok;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arsize  = size;
    bus.arvalid = 1'b1;
    t = 0; hs = 1'b0;
    while (!hs && t < TIMEOUT) begin hs = bus.arready; tick(); t++; end
    bus.arvalid = 1'b0;
    check("ar_handshake", 32'(hs), 1);
    all_ok = 1'b1;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!bus.rvalid && t < TIMEOUT) begin tick(); t++; end
      all_ok     = all_ok && bus.rvalid;
      rd_data[i] = bus.rdata;
      rd_resp[i] = bus.rresp;
      rd_last[i] = bus.rlast;
      if (i == stall_beat) begin
        repeat (3) begin
          tick();
          check("rvalid_stall", 32'(bus.rvalid), 1);
          check("rdata_stall", bus.rdata, stall_exp);
        end
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
    end
    check("r_beats_valid", 32'(all_ok), 1);
    check("rvalid_after_burst", 32'(bus.rvalid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn     = 1'b0;
    bus.awaddr  = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr  = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    tick(); tick();

    // reset state
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready",  32'(bus.wready), 0);
    check("rst_bvalid",  32'(bus.bvalid), 0);
    check("rst_bresp",   32'(bus.bresp), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_rvalid",  32'(bus.rvalid), 0);
    check("rst_rdata",   bus.rdata, 0);
    check("rst_rresp",   32'(bus.rresp), 0);
    check("rst_rlast",   32'(bus.rlast), 0);
    aresetn = 1'b1;
    tick();
    check("idle_awready", 32'(bus.awready), 1);
    check("idle_arready", 32'(bus.arready), 1);

    // seed word 0 so the out-of-range write can be shown not to alias onto it
    wbuf[0] = 32'hA5A5_A5A5;
    axi_write(16'h0000, 0, 3'b010, 0, 1'b1, resp);
    check("seed_bresp", 32'(resp), 0);

    // single beat
    wbuf[0] = 32'hDEAD_BEEF;
    axi_write(16'h0010, 0, 3'b010, 0, 1'b1, resp);
    check("single_bresp", 32'(resp), 0);
    axi_read(16'h0010, 0, 3'b010, -1, 0);
    check("single_rdata", rd_data[0], 32'hDEAD_BEEF);
    check("single_rlast", 32'(rd_last[0]), 1);
    check("single_rresp", 32'(rd_resp[0]), 0);

    // 4-beat burst with BREADY held off 5 cycles and RREADY stalled on beat 2
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    axi_write(16'h0100, 3, 3'b010, 5, 1'b1, resp);
    check("burst4_bresp", 32'(resp), 0);
    axi_read(16'h0100, 3, 3'b010, 1, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst4_rdata[%0d]", i), rd_data[i], 32'(i + 1));
      check($sformatf("burst4_rlast[%0d]", i), 32'(rd_last[i]), 32'(i == 3));
      check($sformatf("burst4_rresp[%0d]", i), 32'(rd_resp[i]), 0);
    end

    // out of range: 0x1000 is the first byte past the RAM
    wbuf[0] = 32'h1234_5678;
    axi_write(16'h1000, 0, 3'b010, 0, 1'b1, resp);
    check("oor_bresp", 32'(resp), 2);
    axi_read(16'h0000, 0, 3'b010, -1, 0);
    check("oor_no_alias", rd_data[0], 32'hA5A5_A5A5);
    axi_read(16'h1000, 0, 3'b010, -1, 0);
    check("oor_rresp", 32'(rd_resp[0]), 2);
    check("oor_rdata", rd_data[0], 0);
    check("oor_rlast", 32'(rd_last[0]), 1);

    // illegal size and misaligned address leave the word untouched
    wbuf[0] = 32'hBAD0_BAD0;
    axi_write(16'h0010, 0, 3'b001, 0, 1'b1, resp);
    check("size_bresp", 32'(resp), 2);
    axi_write(16'h0012, 0, 3'b010, 0, 1'b1, resp);
    check("misalign_bresp", 32'(resp), 2);
    axi_read(16'h0010, 0, 3'b010, -1, 0);
    check("size_no_write", rd_data[0], 32'hDEAD_BEEF);
    axi_read(16'h0010, 0, 3'b001, -1, 0);
    check("size_rresp", 32'(rd_resp[0]), 2);
    check("size_rdata", rd_data[0], 0);

    // missing WLAST on the final beat
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    axi_write(16'h0020, 1, 3'b010, 0, 1'b0, resp);
    check("nolast_bresp", 32'(resp), 2);

    // top word is legal, one more beat runs off the end
    wbuf[0] = 32'h55AA_55AA;
    axi_write(16'h0FFC, 0, 3'b010, 0, 1'b1, resp);
    check("top_bresp", 32'(resp), 0);
    axi_read(16'h0FFC, 0, 3'b010, -1, 0);
    check("top_rdata", rd_data[0], 32'h55AA_55AA);
    check("top_rresp", 32'(rd_resp[0]), 0);
    axi_write(16'h0FFC, 1, 3'b010, 0, 1'b1, resp);
    check("top_over_bresp", 32'(resp), 2);

    // 256-beat burst (AWLEN = ARLEN = 255)
    for (int i = 0; i < 256; i++) wbuf[i] = 32'(i * 3 + 7);
    axi_write(16'h0400, 255, 3'b010, 0, 1'b1, resp);
    check("b256_bresp", 32'(resp), 0);
    axi_read(16'h0400, 255, 3'b010, -1, 0);
    for (int i = 0; i < 256; i++)
      check($sformatf("b256_rdata[%0d]", i), rd_data[i], 32'(i * 3 + 7));
    check("b256_rlast_254", 32'(rd_last[254]), 0);
    check("b256_rlast_255", 32'(rd_last[255]), 1);

    // reset in the middle of a write burst
    bus.awaddr = 16'h0200; bus.awlen = 8'd3; bus.awsize = 3'b010; bus.awvalid = 1'b1;
    check("abort_awready", 32'(bus.awready), 1);
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata  = 32'h1001 + 32'(i);
      bus.wlast  = 1'b0;
      bus.wvalid = 1'b1;
      check($sformatf("abort_wready[%0d]", i), 32'(bus.wready), 1);
      tick();
    end
    aresetn = 1'b0;
    #1;
    check("abort_awready_rst", 32'(bus.awready), 0);
    check("abort_wready_rst",  32'(bus.wready), 0);
    check("abort_bvalid_rst",  32'(bus.bvalid), 0);
    check("abort_arready_rst", 32'(bus.arready), 0);
    check("abort_rvalid_rst",  32'(bus.rvalid), 0);
    bus.wvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    wbuf[0] = 32'h77;
    axi_write(16'h0200, 0, 3'b010, 0, 1'b1, resp);
    check("post_abort_bresp", 32'(resp), 0);
    axi_read(16'h0200, 0, 3'b010, -1, 0);
    check("post_abort_rdata", rd_data[0], 32'h77);
    axi_read(16'h0204, 0, 3'b010, -1, 0);
    check("partial_word_kept", rd_data[0], 32'h1002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
